rv32i_mem_arbiter: RTL and testbench

- Shares the core's single memory-bus master port between three requesters: instruction fetch (if_), load/store data (dm_) and the debug module's system-bus access (dbg_).
- Sits between the control/datapath and the bus adapter.
- Allows at most one outstanding transaction.
- Uses fixed priority with fetch anti-starvation, plus a response timeout that returns an error.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/rv32i_mem_arbiter_if.sv | 23 ++
 rtl/rv32i_arb_pick.sv | 22 ++
 rtl/rv32i_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i memory arbiter: FSM states, requester IDs and the
// latched bus request record.
package rv32i_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2,
        ARB_FLUSH = 2'd3
    } arb_state_e;

    // Values double as bit positions in the one-hot grant vector.
    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_DM  = 2'd1,
        OWN_DBG = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic               we;
        logic [RV_XLEN-1:0] addr;
        logic [RV_XLEN-1:0] wdata;
        logic [3:0]         wstrb;
    } mem_req_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// One memory-port bundle, used both for each requester and for the shared bus.
//
// Handshake: the master raises req with stable fields; the slave accepts on the
// clock edge where req && gnt (requester side: gnt is a one-cycle accept pulse;
// bus side: gnt is m_ready). A later one-cycle rvalid carries rdata/err.
interface rv32i_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (output req, we, addr, wdata, wstrb,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, wstrb,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rv32i_arb_pick.sv
// Combinational arbitration: debug first, then data, then fetch. A starving
// fetch jumps ahead of data but never ahead of debug.
module rv32i_arb_pick (
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       starve_hit,
    output logic [2:0] grant
);
    always_comb begin
        grant = 3'b000;
        if (dbg_req) begin
            grant = 3'b100;
        end else if (if_req && starve_hit) begin
            grant = 3'b001;
        end else if (dm_req) begin
            grant = 3'b010;
        end else if (if_req) begin
            grant = 3'b001;
        end
    end
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares the single memory bus between fetch, data and debug requesters with one
// outstanding transaction, fetch anti-starvation and a response timeout.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int TIMEOUT      = 256,
    parameter  int STARVE_LIMIT = 4,
    localparam int TW           = $clog2(TIMEOUT) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_mem_arbiter_if.slave  ifetch,
    rv32i_mem_arbiter_if.slave  dmem,
    rv32i_mem_arbiter_if.slave  dbg,
    rv32i_mem_arbiter_if.master mbus,
    output logic                busy,
    output arb_state_e          state,
    output logic [SW-1:0]       starve_cnt
);

    arb_state_e      state_d;
    arb_owner_e      owner;
    arb_owner_e      owner_sel;
    mem_req_t        req_q;
    mem_req_t        req_sel;
    logic [2:0]      grant;
    logic [2:0]      gnt_vec;
    logic            starve_hit;
    logic            accept;
    logic            complete;
    logic            tmo_hit;
    logic            tmo_issue;
    logic            tmo_resp;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      rvalid_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q [3];
    logic            unused_fetch;

    // Fetch is read-only; its write fields are never looked at.
    assign unused_fetch = &{1'b0, ifetch.we, ifetch.wdata, ifetch.wstrb};

    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

    rv32i_arb_pick u_pick (
        .if_req     (ifetch.req),
        .dm_req     (dmem.req),
        .dbg_req    (dbg.req),
        .starve_hit (starve_hit),
        .grant      (grant)
    );

    assign gnt_vec   = (state == ARB_IDLE && !rst) ? grant : 3'b000;
    assign accept    = |gnt_vec;
    assign tmo_hit   = (tmo_cnt >= TW'(TIMEOUT - 1));
    assign complete  = (state == ARB_RESP) && mbus.rvalid;
    assign tmo_issue = (state == ARB_ISSUE) && !mbus.gnt && tmo_hit;
    assign tmo_resp  = (state == ARB_RESP) && !mbus.rvalid && tmo_hit;

    always_comb begin
        owner_sel = OWN_IF;
        req_sel   = '0;
        if (grant[2]) begin
            owner_sel     = OWN_DBG;
            req_sel.we    = dbg.we;
            req_sel.addr  = dbg.addr;
            req_sel.wdata = dbg.wdata;
            req_sel.wstrb = dbg.wstrb;
        end else if (grant[1]) begin
            owner_sel     = OWN_DM;
            req_sel.we    = dmem.we;
            req_sel.addr  = dmem.addr;
            req_sel.wdata = dmem.wdata;
            req_sel.wstrb = dmem.wstrb;
        end else begin
            req_sel.addr  = ifetch.addr;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
            ARB_ISSUE: begin
                if (mbus.gnt)     state_d = ARB_RESP;
                else if (tmo_hit) state_d = ARB_IDLE;
            end
            ARB_RESP: begin
                if (mbus.rvalid)  state_d = ARB_IDLE;
                else if (tmo_hit) state_d = ARB_FLUSH;
            end
            ARB_FLUSH: if (mbus.rvalid || tmo_hit) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_IF;
            req_q      <= '0;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            rvalid_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= 1'b0;

            if (accept) begin
                req_q   <= req_sel;
                owner   <= owner_sel;
                tmo_cnt <= '0;
                if (gnt_vec[0])
                    starve_cnt <= '0;
                else if (ifetch.req && !starve_hit)
                    starve_cnt <= starve_cnt + SW'(1);
            end else if (tmo_resp) begin
                // FLUSH reuses the counter to bound its own wait.
                tmo_cnt <= '0;
            end else if (state != ARB_IDLE) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (complete) begin
                rvalid_q[owner] <= 1'b1;
                err_q           <= mbus.err;
                rdata_q[owner]  <= mbus.rdata;
            end else if (tmo_issue || tmo_resp) begin
                rvalid_q[owner] <= 1'b1;
                err_q           <= 1'b1;
                rdata_q[owner]  <= '0;
            end
        end
    end

    assign ifetch.gnt    = gnt_vec[0];
    assign dmem.gnt      = gnt_vec[1];
    assign dbg.gnt       = gnt_vec[2];
    assign ifetch.rvalid = rvalid_q[0];
    assign dmem.rvalid   = rvalid_q[1];
    assign dbg.rvalid    = rvalid_q[2];
    assign ifetch.err    = rvalid_q[0] & err_q;
    assign dmem.err      = rvalid_q[1] & err_q;
    assign dbg.err       = rvalid_q[2] & err_q;
    assign ifetch.rdata  = rdata_q[0];
    assign dmem.rdata    = rdata_q[1];
    assign dbg.rdata     = rdata_q[2];

    assign mbus.req   = (state == ARB_ISSUE);
    assign mbus.we    = req_q.we;
    assign mbus.addr  = req_q.addr;
    assign mbus.wdata = req_q.wdata;
    assign mbus.wstrb = req_q.wstrb;
    assign busy       = (state != ARB_IDLE);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: table of single transactions plus
// hand-written multi-cycle sequences, with response and bus-side scoreboards.
module tb_rv32i_mem_arbiter;
    import rv32i_pkg::*;

    localparam int TIMEOUT      = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int NV           = 7;

    logic clk;
    logic rst;

    rv32i_mem_arbiter_if #(.XLEN(32)) if_bus  ();
    rv32i_mem_arbiter_if #(.XLEN(32)) dm_bus  ();
    rv32i_mem_arbiter_if #(.XLEN(32)) dbg_bus ();
    rv32i_mem_arbiter_if #(.XLEN(32)) m_bus   ();

    logic       busy;
    arb_state_e dut_state;
    logic [2:0] dut_starve;

    rv32i_mem_arbiter #(
        .XLEN         (32),
        .TIMEOUT      (TIMEOUT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ifetch     (if_bus.slave),
        .dmem       (dm_bus.slave),
        .dbg        (dbg_bus.slave),
        .mbus       (m_bus.master),
        .busy       (busy),
        .state      (dut_state),
        .starve_cnt (dut_starve)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [34:0] exp_q[$];      // {owner[1:0], err, rdata[31:0]}
    logic [68:0] exp_bus_q[$];  // {we, addr, wdata, wstrb}
    int gnt_log[$];
    int gnt_cyc, breq_cyc, rv_cyc, rv_total, flush_cycles, starve_at_if;
    arb_state_e state_at_rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    logic [2:0]  gnt_w, rv_w, err_w;
    logic [31:0] rd_w [3];
    assign gnt_w = {dbg_bus.gnt, dm_bus.gnt, if_bus.gnt};
    assign rv_w  = {dbg_bus.rvalid, dm_bus.rvalid, if_bus.rvalid};
    assign err_w = {dbg_bus.err, dm_bus.err, if_bus.err};
    assign rd_w[0] = if_bus.rdata;
    assign rd_w[1] = dm_bus.rdata;
    assign rd_w[2] = dbg_bus.rdata;

    // ---------------- bus responder configuration ----------------
    logic        bus_ready_en = 1'b1;
    logic        bus_hold     = 1'b0;
    int          bus_vdelay   = 0;
    logic [31:0] bus_rdata_v  = '0;
    logic        bus_err_v    = 1'b0;
    logic        late_valid_req = 1'b0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;

    // Monitor then responder, in one process so bus-input updates never race
    // the sampling of the current cycle.
    initial begin
        logic [34:0] e;
        logic [68:0] b;
        m_bus.gnt = 1'b0; m_bus.rvalid = 1'b0; m_bus.rdata = '0; m_bus.err = 1'b0;
        forever begin
            @(negedge clk);
            if (dut_state == ARB_FLUSH) flush_cycles++;
            for (int p = 0; p < 3; p++) begin
                if (gnt_w[p]) begin
                    gnt_log.push_back(p);
                    gnt_cyc = cyc;
                    if (p == 0) starve_at_if = int'(dut_starve);
                end
            end
            if (m_bus.req && m_bus.gnt) begin
                breq_cyc = cyc;
                if (exp_bus_q.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    b = exp_bus_q.pop_front();
                    check("bus_we", m_bus.we, b[68]);
                    check("bus_addr", m_bus.addr, b[67:36]);
                    if (b[68]) begin
                        check("bus_wdata", m_bus.wdata, b[35:4]);
                        check("bus_wstrb", m_bus.wstrb, b[3:0]);
                    end
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (rv_w[p]) begin
                    rv_total++;
                    rv_cyc = cyc;
                    state_at_rv = dut_state;
                    if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("rv_owner", p, e[34:33]);
                        check("rv_err", err_w[p], e[32]);
                        check("rv_rdata", rd_w[p], e[31:0]);
                    end
                end else if (err_w[p]) begin
                    check("err_without_rvalid", 1, 0);
                end
            end
            // responder
            m_bus.rvalid = 1'b0;
            m_bus.err    = 1'b0;
            m_bus.rdata  = 32'hBAD0_0000;
            if (pend) begin
                if (pend_cnt == 0) begin
                    m_bus.rvalid = 1'b1;
                    m_bus.rdata  = bus_rdata_v;
                    m_bus.err    = bus_err_v;
                    pend = 1'b0;
                end else pend_cnt--;
            end else if (late_valid_req) begin
                m_bus.rvalid = 1'b1;
                m_bus.rdata  = 32'h1111_2222;
                late_valid_req = 1'b0;
            end
            if (m_bus.req && m_bus.gnt && !bus_hold) begin
                pend = 1'b1;
                pend_cnt = bus_vdelay;
            end
            m_bus.gnt = bus_ready_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        case (p)
            0: begin if_bus.req = v; if_bus.addr = addr; end
            1: begin dm_bus.req = v; dm_bus.we = we; dm_bus.addr = addr;
                     dm_bus.wdata = wdata; dm_bus.wstrb = wstrb; end
            default: begin dbg_bus.req = v; dbg_bus.we = we; dbg_bus.addr = addr;
                     dbg_bus.wdata = wdata; dbg_bus.wstrb = wstrb; end
        endcase
    endtask

    task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic push_resp, input logic push_bus,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic got;
        logic wex;
        got = 1'b0;
        wex = (p == 0) ? 1'b0 : we;
        @(posedge clk); #1;
        set_req(p, 1'b1, wex, addr, wdata, wstrb);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt_w[p]) begin got = 1'b1; break; end
        end
        check($sformatf("gnt_seen_p%0d", p), got, 1);
        if (got) begin
            if (push_resp) exp_q.push_back({2'(p), exp_err, exp_rdata});
            if (push_bus)  exp_bus_q.push_back({wex, addr, wdata, wstrb});
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            left = exp_q.size() + exp_bus_q.size();
            if (left == 0 && !busy) break;
        end
        check({name, "_drain"}, left, 0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int n, input logic [11:0] ord);
        check({name, "_len"}, gnt_log.size(), n);
        for (int i = 0; i < n && i < gnt_log.size(); i++)
            check(name, gnt_log[i], ord[2*i +: 2]);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] bus_rdata;
        logic        bus_err;
        int          vdelay;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        logic [31:0] r5, r6;
        int rv_before;
        r5 = $urandom;
        r6 = $urandom;
        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 0, 32'h0000_0013, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1, 32'h0, 1'b0};
        vecs[2] = '{2, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 2, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1, 1'b0, 32'h0000_0404, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 0, 32'h1234_5678, 1'b1};
        vecs[4] = '{2, 1'b1, 32'h0000_0008, 32'h55AA_55AA, 4'h3, 32'h0, 1'b0, 3, 32'h0, 1'b0};
        vecs[5] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, r5, 1'b0, int'($urandom_range(0, 5)), r5, 1'b0};
        vecs[6] = '{1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, r6, 1'b0, int'($urandom_range(0, 5)), r6, 1'b0};

        if_bus.req = 0; if_bus.we = 0; if_bus.addr = 0; if_bus.wdata = 0; if_bus.wstrb = 0;
        dm_bus.req = 0; dm_bus.we = 0; dm_bus.addr = 0; dm_bus.wdata = 0; dm_bus.wstrb = 0;
        dbg_bus.req = 0; dbg_bus.we = 0; dbg_bus.addr = 0; dbg_bus.wdata = 0; dbg_bus.wstrb = 0;
        rv_total = 0; flush_cycles = 0; starve_at_if = -1; state_at_rv = ARB_IDLE;

        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_state", dut_state, ARB_IDLE);
        check("rst_starve", dut_starve, 0);
        check("rst_gnt", gnt_w, 0);
        check("rst_rvalid", rv_w, 0);
        check("rst_m_req", m_bus.req, 0);
        check("rst_m_addr", m_bus.addr, 0);
        check("rst_m_fields", {m_bus.we, m_bus.wdata, m_bus.wstrb}, 0);
        check("rst_rdata", {rd_w[0], rd_w[1]}, 0);

        // Table of single transactions.
        for (int i = 0; i < NV; i++) begin
            bus_vdelay  = vecs[i].vdelay;
            bus_rdata_v = vecs[i].bus_rdata;
            bus_err_v   = vecs[i].bus_err;
            do_req(vecs[i].owner, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   1'b1, 1'b1, vecs[i].exp_rdata, vecs[i].exp_err);
            wait_drain($sformatf("vec%0d", i));
            if (i == 0) begin
                check("lat_m_req", breq_cyc - gnt_cyc, 1);
                check("lat_rvalid", rv_cyc - gnt_cyc, 3);
            end
        end
        bus_vdelay = 0; bus_err_v = 1'b0; bus_rdata_v = 32'h0000_0777;

        // dm and dbg together: dbg goes first.
        gnt_log.delete();
        fork
            do_req(1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 32'h0000_0777, 1'b0);
            do_req(2, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0777, 1'b0);
        join
        wait_drain("dbg_dm");
        check_log("order_dbg_dm", 2, {8'h0, 2'(OWN_DM), 2'(OWN_DBG)});

        // Starvation: fetch waits behind STARVE_LIMIT data grants.
        check("starve_pre", dut_starve, 0);
        gnt_log.delete();
        fork
            do_req(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0777, 1'b0);
            for (int k = 0; k < 5; k++)
                do_req(1, 1'b0, 32'h0000_0600 + 32'(k * 4), 32'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0777, 1'b0);
        join
        wait_drain("starve");
        check_log("order_starve", 6,
                  {2'(OWN_DM), 2'(OWN_IF), 2'(OWN_DM), 2'(OWN_DM), 2'(OWN_DM), 2'(OWN_DM)});
        check("starve_at_if_gnt", starve_at_if, STARVE_LIMIT);
        check("starve_post", dut_starve, 0);

        // Timeout in RESP, then a late m_valid that must be swallowed.
        bus_hold = 1'b1;
        do_req(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1);
        wait_drain("tmo_resp");
        check("tmo_resp_state", state_at_rv, ARB_FLUSH);
        rv_before = rv_total;
        late_valid_req = 1'b1;
        wait_cycles(4);
        check("flush_exit_on_valid", busy, 0);
        check("flush_no_extra_rvalid", rv_total - rv_before, 0);

        // Timeout in RESP without a late response: FLUSH gives up by itself.
        flush_cycles = 0;
        do_req(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        wait_drain("tmo_flush");
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("flush_self_exit", busy, 0);
        check("flush_cycles", flush_cycles, TIMEOUT);
        bus_hold = 1'b0;

        // Timeout in ISSUE: bus never ready, back to IDLE directly.
        bus_ready_en = 1'b0;
        do_req(1, 1'b0, 32'h0000_0048, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
        wait_drain("tmo_issue");
        check("tmo_issue_state", state_at_rv, ARB_IDLE);
        bus_ready_en = 1'b1;

        // Stray m_valid while idle has no effect.
        rv_before = rv_total;
        late_valid_req = 1'b1;
        wait_cycles(3);
        check("idle_valid_ignored", rv_total - rv_before, 0);
        check("idle_valid_busy", busy, 0);

        // Reset while waiting in RESP drops the transaction.
        bus_hold = 1'b1;
        do_req(1, 1'b0, 32'h0000_0a00, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 20 && dut_state != ARB_RESP; i++) @(negedge clk);
        check("mid_rst_in_resp", dut_state, ARB_RESP);
        rv_before = rv_total;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_m_addr", m_bus.addr, 0);
        wait_cycles(TIMEOUT + 4);
        check("mid_rst_no_rvalid", rv_total - rv_before, 0);
        bus_hold = 1'b0;
        bus_rdata_v = 32'h0000_0093;
        do_req(0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0093, 1'b0);
        wait_drain("after_rst");

        check("final_exp_q", exp_q.size() + exp_bus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
